pipe_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage MIPS core. It merges stall requests from ID (load-use), EX (single-cycle hazards) and MEM (memory busy), and schedules multi-cycle EX operations (mult/div) through a cycle counter. It also sequences exception flushes with a post-flush guard window. It drives the per-stage stall vector and flush used by PC, IF_ID, ID_EX, EX_MEM and MEM_WB, and keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/pipe_ctrl_if.sv | 42 ++++
 rtl/pipe_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Bundle between the pipeline stages and the central sequencer.
//               master = pipeline side (raises requests, consumes controls)
//               slave  = pipe_ctrl (consumes requests, drives controls)
//   Requests : stallreq_id, stallreq_ex, mem_busy, mc_start, mc_len[CNT_W],
//              excp_req, excp_target[32]
//   Controls : stall[6], flush, new_pc[32], mc_done, busy, stall_cycles[32]
// Revision    : 1.0  initial release
// ============================================================================
interface pipe_ctrl_if #(
  parameter int CNT_W = 6
);
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             mem_busy;
  logic             mc_start;
  logic [CNT_W-1:0] mc_len;
  logic             excp_req;
  logic [31:0]      excp_target;

  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic             mc_done;
  logic             busy;
  logic [31:0]      stall_cycles;

  modport master (
    output stallreq_id, stallreq_ex, mem_busy, mc_start, mc_len,
           excp_req, excp_target,
    input  stall, flush, new_pc, mc_done, busy, stall_cycles
  );

  modport slave (
    input  stallreq_id, stallreq_ex, mem_busy, mc_start, mc_len,
           excp_req, excp_target,
    output stall, flush, new_pc, mc_done, busy, stall_cycles
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Central pipeline sequencer for the 5-stage core. Merges stall
//               requests from ID/EX/MEM, times multi-cycle EX operations,
//               sequences exception flushes with a post-flush guard window and
//               counts stalled cycles (saturating).
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   bus  : pipe_ctrl_if.slave (requests in, stall/flush/new_pc/mc_done/
//          busy/stall_cycles out)
//   stall bit map: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB, 1 = hold stage
// Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl #(
  parameter int CNT_W      = 6,
  parameter int FLUSH_HOLD = 1
) (
  input  wire logic     clk,
  input  wire logic     rst,
  pipe_ctrl_if.slave    bus
);

  localparam logic [1:0] c_st_run   = 2'd0;
  localparam logic [1:0] c_st_multi = 2'd1;
  localparam logic [1:0] c_st_flush = 2'd2;

  localparam logic [5:0] c_stall_id  = 6'b000111;
  localparam logic [5:0] c_stall_ex  = 6'b001111;
  localparam logic [5:0] c_stall_mem = 6'b011111;

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [2:0]       c_hold    = 3'(FLUSH_HOLD);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_hold;
  logic [31:0]      r_stall_cycles;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_hold_nxt;
  logic [CNT_W-1:0] w_len_eff;
  logic [5:0]       w_req_vec;
  logic [5:0]       w_stall;
  logic             w_flush;
  logic             w_mc_done;

  // A zero-length op is treated as a single-cycle op.
  assign w_len_eff = (bus.mc_len == '0) ? c_cnt_one : bus.mc_len;

  // OR of the single-cycle stall requests; mem's vector covers ex and id.
  assign w_req_vec = (bus.stallreq_id ? c_stall_id  : 6'b0) |
                     (bus.stallreq_ex ? c_stall_ex  : 6'b0) |
                     (bus.mem_busy    ? c_stall_mem : 6'b0);

  // State register and performance counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= c_st_run;
      r_cnt          <= '0;
      r_hold         <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hold  <= w_hold_nxt;
      if ((w_stall != 6'b0) && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = r_hold;
    case (r_state)
      c_st_run: begin
        if (bus.excp_req) begin
          w_state_nxt = c_st_flush;
          w_hold_nxt  = c_hold;
        end else if (bus.mc_start) begin
          if (w_len_eff == c_cnt_one) begin
            // Single-cycle op blocked by MEM: finish it from MULTI instead.
            if (bus.mem_busy) begin
              w_state_nxt = c_st_multi;
              w_cnt_nxt   = c_cnt_one;
            end
          end else begin
            w_state_nxt = c_st_multi;
            w_cnt_nxt   = w_len_eff - c_cnt_one;
          end
        end
      end
      c_st_multi: begin
        if (bus.excp_req) begin
          w_state_nxt = c_st_flush;
          w_cnt_nxt   = '0;
          w_hold_nxt  = c_hold;
        end else if (!bus.mem_busy) begin
          if (r_cnt <= c_cnt_one) begin
            w_state_nxt = c_st_run;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - c_cnt_one;
          end
        end
      end
      c_st_flush: begin
        if (r_hold <= 3'd1) begin
          w_state_nxt = c_st_run;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold - 3'd1;
        end
      end
      default: begin
        w_state_nxt = c_st_run;
        w_cnt_nxt   = '0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // Output logic; outputs are forced quiet while reset is held so random
  // request inputs cannot leak a flush or stall out of the idle state.
  always_comb begin
    w_stall   = 6'b0;
    w_flush   = 1'b0;
    w_mc_done = 1'b0;
    if (rst) begin
      case (r_state)
        c_st_run: begin
          if (bus.excp_req) begin
            w_flush = 1'b1;
          end else begin
            w_stall   = w_req_vec | (bus.mc_start ? c_stall_ex : 6'b0);
            w_mc_done = bus.mc_start && (w_len_eff == c_cnt_one) &&
                        !bus.mem_busy;
          end
        end
        c_st_multi: begin
          if (bus.excp_req) begin
            w_flush = 1'b1;
          end else begin
            w_stall   = w_req_vec | c_stall_ex;
            w_mc_done = !bus.mem_busy && (r_cnt <= c_cnt_one);
          end
        end
        c_st_flush: begin
          w_stall = w_req_vec;
        end
        default: begin
          w_stall = 6'b0;
        end
      endcase
    end
  end

  assign bus.stall        = w_stall;
  assign bus.flush        = w_flush;
  assign bus.new_pc       = w_flush ? bus.excp_target : 32'h0;
  assign bus.mc_done      = w_mc_done;
  assign bus.busy         = (r_state != c_st_run);
  assign bus.stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed-vector bench for pipe_ctrl. Each driven cycle pushes
//               its hand-derived expected outputs into a queue; a monitor on
//               the falling edge pops and compares.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam logic [5:0] S0   = 6'b000000;
  localparam logic [5:0] SID  = 6'b000111;
  localparam logic [5:0] SEX  = 6'b001111;
  localparam logic [5:0] SMEM = 6'b011111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(6)) bus ();

  pipe_ctrl #(.CNT_W(6), .FLUSH_HOLD(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          n;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        done;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_step = 0;
  logic [31:0] m_cnt  = 32'h0;

  // One clock cycle: drive inputs after the edge, queue the expectation.
  task automatic step(input logic r, input logic id, input logic ex,
                      input logic mb, input logic ms, input logic [5:0] len,
                      input logic xr, input logic [31:0] tgt,
                      input logic [5:0] es, input logic ef,
                      input logic [31:0] epc, input logic ed, input logic eb);
    exp_t e;
    @(posedge clk);
    #1;
    rst                 = r;
    bus.stallreq_id     = id;
    bus.stallreq_ex     = ex;
    bus.mem_busy        = mb;
    bus.mc_start        = ms;
    bus.mc_len          = len;
    bus.excp_req        = xr;
    bus.excp_target     = tgt;
    if (!r) m_cnt = 32'h0;
    e.n = n_step; e.stall = es; e.flush = ef; e.pc = epc;
    e.done = ed; e.busy = eb; e.cnt = m_cnt;
    q.push_back(e);
    n_step++;
    if (es != S0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
  endtask

  task automatic idle(input logic eb);
    step(1, 0, 0, 0, 0, 6'd0, 0, 32'h0, S0, 0, 32'h0, 0, eb);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if (bus.stall !== e.stall || bus.flush !== e.flush || bus.new_pc !== e.pc ||
          bus.mc_done !== e.done || bus.busy !== e.busy || bus.stall_cycles !== e.cnt) begin
        n_fail++;
        $display("FAIL step%0d: got stall=%b flush=%b new_pc=%h mc_done=%b busy=%b cnt=%0d, want stall=%b flush=%b new_pc=%h mc_done=%b busy=%b cnt=%0d",
                 e.n, bus.stall, bus.flush, bus.new_pc, bus.mc_done, bus.busy, bus.stall_cycles,
                 e.stall, e.flush, e.pc, e.done, e.busy, e.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.mem_busy = 0; bus.mc_start = 0;
    bus.mc_len = '0; bus.excp_req = 0; bus.excp_target = '0;

    // Reset held with random requests: outputs stay quiet
    for (int i = 0; i < 3; i++)
      step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 6'($urandom),
           1'($urandom), $urandom, S0, 0, 32'h0, 0, 0);
    idle(0); idle(0);

    // Priority merge
    step(1, 1, 0, 0, 0, 6'd0, 0, 32'h0,   SID,  0, 32'h0,   0, 0);
    step(1, 1, 1, 0, 0, 6'd0, 0, 32'h0,   SEX,  0, 32'h0,   0, 0);
    step(1, 1, 1, 1, 0, 6'd0, 0, 32'h0,   SMEM, 0, 32'h0,   0, 0);
    step(1, 1, 1, 1, 0, 6'd0, 1, 32'h380, S0,   1, 32'h380, 0, 0);
    idle(1);
    idle(0);

    // 32-cycle op; a stray mc_start mid-op is ignored
    step(1, 0, 0, 0, 1, 6'd32, 0, 32'h0, SEX, 0, 32'h0, 0, 0);
    for (int i = 2; i <= 31; i++)
      step(1, 0, 0, 0, (i == 10), 6'd5, 0, 32'h0, SEX, 0, 32'h0, 0, 1);
    step(1, 0, 0, 0, 0, 6'd0, 0, 32'h0, SEX, 0, 32'h0, 1, 1);
    idle(0);

    // Zero and one length ops complete in the start cycle
    step(1, 0, 0, 0, 1, 6'd0, 0, 32'h0, SEX, 0, 32'h0, 1, 0);
    idle(0);
    step(1, 0, 0, 0, 1, 6'd1, 0, 32'h0, SEX, 0, 32'h0, 1, 0);
    idle(0);

    // Length 4 with MEM busy for three cycles mid-op: 7 stall cycles
    step(1, 0, 0, 0, 1, 6'd4, 0, 32'h0, SEX, 0, 32'h0, 0, 0);
    step(1, 0, 0, 0, 0, 6'd0, 0, 32'h0, SEX, 0, 32'h0, 0, 1);
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 1, 0, 6'd0, 0, 32'h0, SMEM, 0, 32'h0, 0, 1);
    step(1, 0, 0, 0, 0, 6'd0, 0, 32'h0, SEX, 0, 32'h0, 0, 1);
    step(1, 0, 0, 0, 0, 6'd0, 0, 32'h0, SEX, 0, 32'h0, 1, 1);
    idle(0);

    // Abort in cycle 5, guard window, then a honoured request
    step(1, 0, 0, 0, 1, 6'd32, 0, 32'h0, SEX, 0, 32'h0, 0, 0);
    for (int i = 2; i <= 4; i++)
      step(1, 0, 0, 0, 0, 6'd0, 0, 32'h0, SEX, 0, 32'h0, 0, 1);
    step(1, 0, 0, 0, 0, 6'd0, 1, 32'h8000_0180, S0, 1, 32'h8000_0180, 0, 1);
    step(1, 0, 0, 0, 1, 6'd3, 1, 32'hDEAD_BEEF, S0, 0, 32'h0, 0, 1);
    step(1, 0, 0, 0, 0, 6'd0, 1, 32'h0000_1000, S0, 1, 32'h0000_1000, 0, 0);
    step(1, 0, 0, 1, 0, 6'd0, 0, 32'h0, SMEM, 0, 32'h0, 0, 1);
    for (int i = 0; i < 4; i++) idle(0);

    // Single-cycle op while MEM busy: done on first free cycle
    step(1, 0, 0, 1, 1, 6'd1, 0, 32'h0, SMEM, 0, 32'h0, 0, 0);
    step(1, 0, 0, 0, 0, 6'd0, 0, 32'h0, SEX,  0, 32'h0, 1, 1);
    idle(0);

    // Reset mid-op: no done or flush afterwards
    step(1, 0, 0, 0, 1, 6'd10, 0, 32'h0, SEX, 0, 32'h0, 0, 0);
    step(1, 0, 0, 0, 0, 6'd0,  0, 32'h0, SEX, 0, 32'h0, 0, 1);
    step(0, 0, 0, 0, 0, 6'd0,  1, 32'h1234, S0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 12; i++) idle(0);

    // Counter: 40 stall cycles from a clean reset
    step(0, 0, 0, 0, 0, 6'd0, 0, 32'h0, S0, 0, 32'h0, 0, 0);
    idle(0);
    for (int i = 0; i < 40; i++)
      step(1, 1, 0, 0, 0, 6'd0, 0, 32'h0, SID, 0, 32'h0, 0, 0);
    idle(0);

    // Saturation: preload just below the top, then keep stalling
    @(posedge clk);
    #2;
    force dut.r_stall_cycles = 32'hFFFF_FFFD;
    #1;
    release dut.r_stall_cycles;
    m_cnt = 32'hFFFF_FFFD;
    for (int i = 0; i < 5; i++)
      step(1, 1, 0, 0, 0, 6'd0, 0, 32'h0, SID, 0, 32'h0, 0, 0);
    idle(0); idle(0);

    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
